// File: rtl/deser_pkg.sv
// Shared types for the serial deserializer.
//   deser_state_t : receive FSM state encoding (IDLE, RECV, PAR)
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        PAR  = 2'd2
    } deser_state_t;

endpackage

// File: rtl/sipo_out_stage.sv
// One-entry holding register with valid/ready handshake for assembled words.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : a completed word (data, perr) is offered this cycle
//   data, perr  : completed word and its parity flag
//   out_ready   : consumer accepts when out_valid & out_ready
//   out_data    : held word, stable while out_valid=1
//   out_valid   : word available
//   parity_err  : parity flag registered alongside out_data
//   overrun     : 1-cycle pulse when a completed word is dropped
module sipo_out_stage #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  perr,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  parity_err,
    output logic                  overrun
);

    logic can_load;

    // A transfer in the same cycle frees the slot, so back-to-back words load with no bubble.
    assign can_load = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load && can_load) begin
                out_data   <= data;
                out_valid  <= 1'b1;
                parity_err <= perr;
            end else if (load) begin
                overrun <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid  <= 1'b0;
                parity_err <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: shifts a 1-bit stream into DATA_WIDTH-bit words and
// presents each on a valid/ready port.
// Optional feature macro: SHIFT_PARITY_EN (adds one even-parity bit per frame).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   ser_valid, ser_data : serial bit and its qualifier
//   ser_sync            : realign; discards partial word, a valid bit here becomes bit 0
//   msb_first           : bit order, sampled on the first bit of each word
//   out_data, out_valid, out_ready : parallel word handshake
//   overrun             : completed word dropped because output register was occupied
//   busy                : partial word in progress
//   parity_err          : parity flag for out_data (0 without SHIFT_PARITY_EN)
//
// state | meaning
// IDLE  | no bits of a word received
// RECV  | data bits 1..DATA_WIDTH-1 being collected
// PAR   | all data bits held, waiting for the parity bit (SHIFT_PARITY_EN only)
module serial_deserializer
    import deser_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ser_valid,
    input  logic                  ser_data,
    input  logic                  ser_sync,
    input  logic                  msb_first,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun,
    output logic                  busy,
    output logic                  parity_err
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    deser_state_t            state;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   sr;
    logic [DATA_WIDTH-1:0]   sr_next;
    logic                    order_q;
    logic                    order_use;
    logic                    complete;
    logic [DATA_WIDTH-1:0]   word;
    logic                    word_perr;

    // The first bit of a word (from IDLE or a realign) uses the live msb_first; later bits use the latched order.
    always_comb begin
        order_use = (ser_sync || state == IDLE) ? msb_first : order_q;
        sr_next   = order_use ? {sr[DATA_WIDTH-2:0], ser_data}
                              : {ser_data, sr[DATA_WIDTH-1:1]};
    end

`ifdef SHIFT_PARITY_EN
    assign complete  = ser_valid && !ser_sync && (state == PAR);
    assign word      = sr;
    assign word_perr = ^{sr, ser_data};
`else
    assign complete  = ser_valid && !ser_sync && (state == RECV) && (cnt == LAST_CNT);
    assign word      = sr_next;
    assign word_perr = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            sr      <= '0;
            order_q <= 1'b0;
        end else if (ser_sync) begin
            if (ser_valid) begin
                sr      <= sr_next;
                order_q <= msb_first;
                cnt     <= CNT_ONE;
                state   <= RECV;
            end else begin
                cnt     <= '0;
                state   <= IDLE;
            end
        end else if (ser_valid) begin
            case (state)
                IDLE: begin
                    sr      <= sr_next;
                    order_q <= msb_first;
                    cnt     <= CNT_ONE;
                    state   <= RECV;
                end
                RECV: begin
                    sr <= sr_next;
                    if (cnt == LAST_CNT) begin
`ifdef SHIFT_PARITY_EN
                        cnt   <= cnt + CNT_ONE;
                        state <= PAR;
`else
                        cnt   <= '0;
                        state <= IDLE;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PAR: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    sipo_out_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (complete),
        .data       (word),
        .perr       (word_perr),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed self-checking bench for serial_deserializer (DATA_WIDTH=8).
// Build with SHIFT_PARITY_EN defined to exercise the parity frame.
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ser_valid, ser_data, ser_sync, msb_first;
    logic [7:0] out_data;
    logic       out_valid, out_ready, overrun, busy, parity_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_deserializer #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ser_valid  (ser_valid),
        .ser_data   (ser_data),
        .ser_sync   (ser_sync),
        .msb_first  (msb_first),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .busy       (busy),
        .parity_err (parity_err)
    );

    // stream[7] is the first bit on the wire
    typedef struct {
        logic [7:0] stream;
        logic       msb;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sends one frame. msb_first is driven to the opposite order after the first bit
    // to confirm the order is latched per word. Returns at the negedge after the final
    // bit's capture edge, where out_valid should be visible.
    task automatic send_word(input logic [7:0] stream, input logic msb, input logic sync_first,
                             input logic rdy_last, input logic par_bad, input logic chk_busy);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            if (chk_busy) chk("busy_mid", busy, 1);
            ser_valid = 1'b1;
            ser_data  = stream[i];
            ser_sync  = sync_first && (i == 7);
            msb_first = (i == 7) ? msb : ~msb;
`ifndef SHIFT_PARITY_EN
            if (rdy_last && i == 0) out_ready = 1'b1;
`endif
        end
`ifdef SHIFT_PARITY_EN
        @(negedge clk);
        if (chk_busy) chk("busy_par", busy, 1);
        ser_sync  = 1'b0;
        ser_data  = (^stream) ^ par_bad;
        msb_first = ~msb;
        if (rdy_last) out_ready = 1'b1;
`endif
        @(negedge clk);
        ser_valid = 1'b0;
        ser_sync  = 1'b0;
        ser_data  = 1'b0;
    endtask

    task automatic send_bits(input int n, input logic [7:0] bits);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ser_valid = 1'b1;
            ser_data  = bits[i];
            msb_first = 1'b1;
        end
        @(negedge clk);
        ser_valid = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{stream: 8'hA5, msb: 1'b1, exp: 8'hA5};
        vecs[1] = '{stream: 8'h78, msb: 1'b0, exp: 8'h1E};
        vecs[2] = '{stream: 8'h78, msb: 1'b1, exp: 8'h78};
        vecs[3] = '{stream: 8'h80, msb: 1'b0, exp: 8'h01};
        vecs[4] = '{stream: 8'hC4, msb: 1'b0, exp: 8'h23};
        vecs[5] = '{stream: 8'hFF, msb: 1'b1, exp: 8'hFF};
        vecs[6] = '{stream: 8'h01, msb: 1'b1, exp: 8'h01};

        rst_n = 1'b0; ser_valid = 1'b0; ser_data = 1'b0; ser_sync = 1'b0;
        msb_first = 1'b1; out_ready = 1'b1;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_perr", parity_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: single words with out_ready=1, 1-cycle valid pulse.
        for (int v = 0; v < 7; v++) begin
            send_word(vecs[v].stream, vecs[v].msb, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("tbl_valid", out_valid, 1);
            chk("tbl_data", out_data, vecs[v].exp);
            chk("tbl_overrun", overrun, 0);
            chk("tbl_perr", parity_err, 0);
            @(negedge clk);
            chk("tbl_valid_drop", out_valid, 0);
            chk("tbl_busy_idle", busy, 0);
        end

        // Overrun: consumer stalled, second word dropped.
        out_ready = 1'b0;
        send_word(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_first_valid", out_valid, 1);
        chk("ovr_first_data", out_data, 8'h11);
        send_word(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_pulse", overrun, 1);
        chk("ovr_hold_data", out_data, 8'h11);
        @(negedge clk);
        chk("ovr_pulse_end", overrun, 0);
        chk("ovr_hold_valid", out_valid, 1);
        chk("ovr_hold_data2", out_data, 8'h11);

        // Back-to-back: 8'h33 completes on the edge that transfers 8'h11.
        send_word(8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b0;
        chk("b2b_data", out_data, 8'h33);
        chk("b2b_valid", out_valid, 1);
        chk("b2b_overrun", overrun, 0);
        @(negedge clk);
        chk("b2b_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_drain", out_valid, 0);

        // Realign after 3 stray bits.
        send_bits(3, 8'b0000_0101);
        chk("sync_busy_pre", busy, 1);
        send_word(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("sync_data", out_data, 8'hC3);
        chk("sync_valid", out_valid, 1);
        chk("sync_busy_done", busy, 0);
        @(negedge clk);
        chk("sync_single", out_valid, 0);

        // Reset mid-word.
        send_bits(4, 8'b0000_1011);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_data", out_data, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_word(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mrst_next_data", out_data, 8'h5A);
        chk("mrst_next_valid", out_valid, 1);

`ifdef SHIFT_PARITY_EN
        @(negedge clk);
        send_word(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("par_bad_flag", parity_err, 1);
        chk("par_bad_data", out_data, 8'h01);
        chk("par_bad_valid", out_valid, 1);
        @(negedge clk);
        send_word(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("par_ok_flag", parity_err, 0);
        chk("par_ok_data", out_data, 8'h01);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
